// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS-I subset core.
package mips_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          LINE_WORDS = 8;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_EXEC,
    S_LOAD_WAIT,
    S_STORE
  } state_e;

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port. r0 always reads zero and writes to it are discarded.
module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  // Write port; r0 is never stored so its entry stays unused.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];

endmodule

// File: rtl/cpu.sv
// Multicycle MIPS-I integer subset core. Every instruction is fetched as an
// 8-word line fill, loads are line fills, stores are single write cycles.
module cpu
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        MRST,
  inout  wire  [31:0] Bus,
  output logic [31:0] Addr,
  output logic        Read,
  output logic        Write,
  input  logic        Valid
);

  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d, addr_q, addr_d;
  logic [2:0]  beat_q, beat_d;
  logic        read_q, read_d, write_q, write_d;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, zext_imm, rs_val, rt_val, ea, jump_tgt;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'd0, ir_q[15:0]};
  assign ea       = rs_val + sext_imm;
  assign jump_tgt = {npc_q[31:28], ir_q[25:0], 2'b00};

  // Register file; port b also supplies store data during STORE.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  cpu_regfile u_regfile (
    .clk_i     (CLK),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (rt),
    .rdata_b_o (rt_val)
  );

  assign Addr  = addr_q;
  assign Read  = read_q;
  assign Write = write_q;
  assign Bus   = write_q ? rt_val : 32'bz;

  // ALU result, destination and the pc that follows the delay slot.
  logic [31:0] alu_res, next_npc;
  logic        alu_we;
  logic [4:0]  alu_dst;

  // Decode and ALU: one result per instruction, written back in EXEC.
  always_comb begin
    alu_res  = 32'd0;
    alu_we   = 1'b0;
    alu_dst  = rt;
    next_npc = npc_q + 32'd4;
    case (op)
      OP_SPECIAL: begin
        alu_dst = rd;
        alu_we  = 1'b1;
        case (funct)
          FN_ADDU: alu_res = rs_val + rt_val;
          FN_SUBU: alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_XOR:  alu_res = rs_val ^ rt_val;
          FN_NOR:  alu_res = ~(rs_val | rt_val);
          FN_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: alu_res = {31'd0, rs_val < rt_val};
          FN_SLL:  alu_res = rt_val << shamt;
          FN_SRL:  alu_res = rt_val >> shamt;
          FN_SRA:  alu_res = $unsigned($signed(rt_val) >>> shamt);
          FN_JR: begin
            alu_we   = 1'b0;
            next_npc = rs_val;
          end
          FN_JALR: begin
            alu_res  = pc_q + 32'd8;
            next_npc = rs_val;
          end
          default: alu_we = 1'b0;
        endcase
      end
      OP_J:   next_npc = jump_tgt;
      OP_JAL: begin
        next_npc = jump_tgt;
        alu_res  = pc_q + 32'd8;
        alu_we   = 1'b1;
        alu_dst  = 5'd31;
      end
      OP_BEQ: if (rs_val == rt_val) next_npc = npc_q + (sext_imm << 2);
      OP_BNE: if (rs_val != rt_val) next_npc = npc_q + (sext_imm << 2);
      OP_ADDIU: begin alu_res = rs_val + sext_imm;                       alu_we = 1'b1; end
      OP_SLTI:  begin alu_res = {31'd0, $signed(rs_val) < $signed(sext_imm)}; alu_we = 1'b1; end
      OP_SLTIU: begin alu_res = {31'd0, rs_val < sext_imm};              alu_we = 1'b1; end
      OP_ANDI:  begin alu_res = rs_val & zext_imm;                       alu_we = 1'b1; end
      OP_ORI:   begin alu_res = rs_val | zext_imm;                       alu_we = 1'b1; end
      OP_XORI:  begin alu_res = rs_val ^ zext_imm;                       alu_we = 1'b1; end
      OP_LUI:   begin alu_res = {ir_q[15:0], 16'd0};                     alu_we = 1'b1; end
      default: ;
    endcase
  end

  // Sequencer: next state and bus/register controls for each phase.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    read_d   = read_q;
    write_d  = write_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        addr_d  = pc_q;
        read_d  = 1'b1;
        beat_d  = 3'd0;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (Valid) begin
          if (beat_q == pc_q[4:2]) ir_d = Bus;
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            read_d  = 1'b0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        pc_d     = npc_q;
        npc_d    = next_npc;
        rf_we    = alu_we;
        rf_waddr = alu_dst;
        rf_wdata = alu_res;
        state_d  = S_FETCH;
        if (op == OP_LW) begin
          addr_d  = ea;
          read_d  = 1'b1;
          beat_d  = 3'd0;
          state_d = S_LOAD_WAIT;
        end else if (op == OP_SW) begin
          addr_d  = ea;
          write_d = 1'b1;
          state_d = S_STORE;
        end
      end
      S_LOAD_WAIT: begin
        if (Valid) begin
          if (beat_q == addr_q[4:2]) begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = Bus;
          end
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            read_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_STORE: begin
        write_d = 1'b0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers; reset aborts any fill or store immediately.
  always_ff @(posedge CLK or negedge MRST) begin
    if (!MRST) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      ir_q    <= 32'd0;
      addr_q  <= 32'd0;
      beat_q  <= 3'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: a line-fill memory responder, an instruction-level reference
// model that predicts every bus transaction, and a monitor that checks them.
`timescale 1ns/1ps
module tb_cpu;

  logic        CLK, MRST, Valid;
  logic [31:0] Addr;
  logic        Read, Write;
  wire  [31:0] bus;
  logic        mem_oe;
  logic [31:0] mem_dq;

  assign bus = mem_oe ? mem_dq : 32'bz;

  cpu dut (
    .CLK   (CLK),
    .MRST  (MRST),
    .Bus   (bus),
    .Addr  (Addr),
    .Read  (Read),
    .Write (Write),
    .Valid (Valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem [1024];   // live memory seen by the DUT (4 KB, wraps)
  logic [31:0] mm  [1024];   // reference model's private copy
  int          n_checks = 0;
  int          n_fail   = 0;
  int          beat_limit = 8;
  bit          fill_stalled = 0;
  int          rfn_tab [13];
  int          iop_tab [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input logic [25:0] t);
    return {6'(op), t};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd, sh;
    logic [15:0] imm;
    k   = $urandom_range(0, 29);
    rs  = $urandom_range(0, 31);
    rt  = $urandom_range(0, 31);
    rd  = $urandom_range(0, 31);
    sh  = $urandom_range(0, 31);
    imm = ($urandom_range(0, 1) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 64));
    if (k < 13)      return enc_r(rs, rt, rd, sh, rfn_tab[k]);
    else if (k < 24) return enc_i(iop_tab[k-13], rs, rt, imm);
    else if (k < 26) return enc_j(k - 22, 26'($urandom()));   // J / JAL
    else if (k < 28) return $urandom();                         // arbitrary word
    else             return enc_r(rs, rt, rd, sh, 1);           // unused funct
  endfunction

  // Instruction-level reference: executes n instructions from pc 0 and queues
  // the fills and stores they cause, in order.
  task automatic model_run(input int n);
    logic [31:0] r [32];
    logic [31:0] pc, npc, nn, ir, a, b, se, ze, ea, res;
    int          wr;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc  = 32'd0;
    npc = 32'd4;
    for (int s = 0; s < n; s++) begin
      ir  = mm[pc[11:2]];
      q.push_back('{1'b0, pc, 32'd0});
      a   = r[ir[25:21]];
      b   = r[ir[20:16]];
      se  = {{16{ir[15]}}, ir[15:0]};
      ze  = {16'd0, ir[15:0]};
      nn  = npc + 4;
      wr  = 0;
      res = 32'd0;
      case (int'(ir[31:26]))
        0: begin
          wr = int'(ir[15:11]);
          case (int'(ir[5:0]))
            33: res = a + b;
            35: res = a - b;
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = ~(a | b);
            42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            43: res = (a < b) ? 32'd1 : 32'd0;
            0:  res = b << ir[10:6];
            2:  res = b >> ir[10:6];
            3:  res = $unsigned($signed(b) >>> ir[10:6]);
            8:  begin nn = a; wr = 0; end
            9:  begin nn = a; res = pc + 8; end
            default: wr = 0;
          endcase
        end
        2:  nn = {npc[31:28], ir[25:0], 2'b00};
        3:  begin nn = {npc[31:28], ir[25:0], 2'b00}; res = pc + 8; wr = 31; end
        4:  if (a == b) nn = npc + (se << 2);
        5:  if (a != b) nn = npc + (se << 2);
        9:  begin res = a + se; wr = int'(ir[20:16]); end
        10: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = int'(ir[20:16]); end
        11: begin res = (a < se) ? 32'd1 : 32'd0; wr = int'(ir[20:16]); end
        12: begin res = a & ze; wr = int'(ir[20:16]); end
        13: begin res = a | ze; wr = int'(ir[20:16]); end
        14: begin res = a ^ ze; wr = int'(ir[20:16]); end
        15: begin res = {ir[15:0], 16'd0}; wr = int'(ir[20:16]); end
        35: begin
          ea = a + se;
          q.push_back('{1'b0, ea, 32'd0});
          res = mm[ea[11:2]];
          wr  = int'(ir[20:16]);
        end
        43: begin
          ea = a + se;
          q.push_back('{1'b1, ea, b});
          mm[ea[11:2]] = b;
        end
        default: ;
      endcase
      if (wr != 0) r[wr] = res;
      pc  = npc;
      npc = nn;
    end
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0]  = enc_i(9, 0, 1, 16'd5);          // ADDIU r1,r0,5
    mem[1]  = enc_r(1, 1, 2, 0, 33);          // ADDU  r2,r1,r1
    mem[2]  = enc_i(43, 0, 2, 16'h40);        // SW    r2,0x40(r0)
    mem[3]  = enc_i(35, 0, 3, 16'h24);        // LW    r3,0x24(r0)
    mem[4]  = enc_i(43, 0, 3, 16'h44);        // SW    r3,0x44(r0)
    mem[5]  = enc_i(4, 0, 0, 16'd4);          // BEQ   r0,r0,+4 -> 0x28
    mem[6]  = enc_i(9, 0, 4, 16'd7);          // ADDIU r4,r0,7 (delay slot)
    mem[7]  = enc_i(9, 0, 4, 16'd9);          // skipped
    mem[9]  = 32'hDEAD_BEEF;                  // load data, beat 1 of line 0x20
    mem[10] = enc_i(43, 0, 4, 16'h48);        // SW    r4,0x48(r0)
    mem[11] = enc_j(2, 26'h00B);              // J     0x2C
  endtask

  task automatic push_fill(input logic [31:0] a);
    q.push_back('{1'b0, a, 32'd0});
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    q.push_back('{1'b1, a, d});
  endtask

  task automatic drain(input int budget, input string nm);
    int c;
    c = 0;
    while (q.size() != 0 && c < budget) begin
      @(negedge CLK);
      c++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d transactions outstanding, required 0", nm, q.size());
      q.delete();
    end
  endtask

  // Memory responder: latency of at least 200 ns, then 8 beats with gaps.
  initial begin
    logic [31:0] base;
    int          lat;
    mem_oe = 1'b0;
    mem_dq = 32'd0;
    Valid  = 1'b0;
    forever begin
      @(negedge CLK);
      if (MRST && Read) begin
        base = Addr;
        lat  = 20 + $urandom_range(0, 3);
        for (int w = 0; w < lat; w++) begin
          @(negedge CLK);
          if (!MRST) break;
        end
        for (int b = 0; b < 8; b++) begin
          if (!MRST) break;
          if (b >= beat_limit) begin
            fill_stalled = 1'b1;
            wait (!MRST);
            break;
          end
          repeat ($urandom_range(0, 2)) @(negedge CLK);
          if (!MRST) break;
          Valid  = 1'b1;
          mem_oe = 1'b1;
          mem_dq = mem[{base[11:5], 3'(b)}];
          @(negedge CLK);
          Valid  = 1'b0;
          mem_oe = 1'b0;
        end
      end
    end
  end

  // Monitor: every fill request and store strobe is matched against the queue.
  initial begin
    bit          read_prev;
    bit          moved;
    logic [31:0] fill_addr;
    txn_t        e;
    read_prev = 1'b0;
    moved     = 1'b0;
    fill_addr = 32'd0;
    forever begin
      @(negedge CLK);
      if (Read && !read_prev) begin
        fill_addr = Addr;
        moved     = 1'b0;
        $display("txn fill  addr=%h", Addr);
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_fill: got addr %h, required no transaction", Addr);
        end else begin
          e = q.pop_front();
          if (e.is_store || (Addr & ~32'd3) !== (e.addr & ~32'd3)) begin
            n_fail++;
            $display("FAIL fill: got fill addr %h, required %s addr %h",
                     Addr, e.is_store ? "store" : "fill", e.addr);
          end
        end
      end else if (Read && read_prev && Addr !== fill_addr) begin
        moved = 1'b1;
      end
      if (!Read && read_prev && MRST) chk("fill_addr_stable", {31'd0, moved}, 32'd0);
      if (Write) begin
        $display("txn store addr=%h data=%h", Addr, bus);
        chk("rw_exclusive", {31'd0, Read}, 32'd0);
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_store: got addr %h data %h, required no transaction", Addr, bus);
        end else begin
          e = q.pop_front();
          if (!e.is_store || (Addr & ~32'd3) !== (e.addr & ~32'd3) || bus !== e.data) begin
            n_fail++;
            $display("FAIL store: got store addr %h data %h, required %s addr %h data %h",
                     Addr, bus, e.is_store ? "store" : "fill", e.addr, e.data);
          end
        end
        mem[Addr[11:2]] = bus;
      end
      read_prev = Read;
    end
  end

  initial begin
    int c;
    rfn_tab = '{33, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 8, 9};
    iop_tab = '{9, 10, 11, 12, 13, 14, 15, 35, 43, 4, 5};
    MRST = 1'b0;

    // Reset state and the first request after release
    load_directed();
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_read",  {31'd0, Read},  32'd0);
    chk("reset_write", {31'd0, Write}, 32'd0);
    chk("reset_addr",  Addr,           32'd0);
    push_fill(32'h00); push_fill(32'h04); push_fill(32'h08);
    push_store(32'h40, 32'd10);
    push_fill(32'h0C); push_fill(32'h24);
    push_fill(32'h10);
    push_store(32'h44, 32'hDEAD_BEEF);
    push_fill(32'h14); push_fill(32'h18); push_fill(32'h28);
    push_store(32'h48, 32'd7);
    push_fill(32'h2C); push_fill(32'h30);
    @(negedge CLK);
    MRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("first_read", {31'd0, Read}, 32'd1);
    chk("first_addr", Addr,          32'd0);
    drain(5000, "directed");
    MRST = 1'b0;

    // Randomised program: prologue defines r1..r31, the rest is random code
    for (int i = 1; i < 32; i++) begin
      mem[2*i-2] = enc_i(15, 0, i, 16'($urandom()));
      mem[2*i-1] = enc_i(13, i, i, 16'($urandom()));
    end
    for (int i = 62; i < 1024; i++) mem[i] = rand_instr();
    for (int i = 0; i < 1024; i++) mm[i] = mem[i];
    model_run(62 + 150);
    @(negedge CLK);
    MRST = 1'b1;
    drain(40000, "random");
    MRST = 1'b0;

    // Reset in the middle of a fill, after beat 3
    load_directed();
    push_fill(32'h00);
    beat_limit   = 4;
    fill_stalled = 1'b0;
    @(negedge CLK);
    MRST = 1'b1;
    c = 0;
    while (!fill_stalled && c < 500) begin
      @(negedge CLK);
      c++;
    end
    chk("midfill_stalled", {31'd0, fill_stalled}, 32'd1);
    repeat (2) @(negedge CLK);
    chk("midfill_read_before", {31'd0, Read}, 32'd1);
    #2;
    MRST = 1'b0;
    #1;
    chk("midfill_read_drop",  {31'd0, Read},  32'd0);
    chk("midfill_write_low",  {31'd0, Write}, 32'd0);
    chk("midfill_addr_reset", Addr,           32'd0);
    beat_limit   = 8;
    push_fill(32'h00);
    @(negedge CLK);
    fill_stalled = 1'b0;
    MRST = 1'b1;
    drain(500, "restart");
    MRST = 1'b0;

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Non-pipelined, multicycle MIPS-I integer subset core: the processor instantiated under the system top, talking to external memory over a shared 32-bit tri-state bus. Instructions and load data arrive as 8-word (32-byte) line fills. Stores are single-word write-through cycles. No caches inside this block.

## Interface
- No parameters. Constants: `RESET_PC` = 32'h0000_0000; `LINE_WORDS` = 8.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `MRST`  in  1  reset, asynchronous, active-low.
- `Bus`  inout  32  read data from memory during fills; write data from the CPU only while `Write`=1, otherwise high-Z.
- `Addr`  out  32  byte address of the current fill or write.
- `Read`  out  1  line-fill request; held high until the fill completes.
- `Write`  out  1  one-cycle word store strobe.
- `Valid`  in  1  high for each fill beat carrying a valid word on `Bus`.

## Operation
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
  - Any other encoding executes as a NOP. No exceptions; overflow is ignored.
- Register file: 32×32; r0 reads 0 and writes to it are dropped. JAL and JALR link PC+8.
- Immediates: ANDI/ORI/XORI zero-extend, all others sign-extend. SLTU/SLTIU compare unsigned.
- Branch delay slot (one instruction): the instruction after a branch or jump always executes. Branch target = delay-slot PC + (sext(imm)<<2). Implemented with `pc`/`npc` registers.
- Loads and stores use word-aligned addresses; address bits [1:0] are ignored.
- FSM states: FETCH → FETCH_WAIT → EXEC → (LOAD_WAIT | STORE) → FETCH.
  - FETCH: drive `Addr`=pc, raise `Read`.
  - FETCH_WAIT: count `Valid` beats 0..7. Latch `Bus` into IR on the beat whose index equals pc[4:2]. On beat 7, drop `Read` and go to EXEC.
  - EXEC: ALU operation and register writeback, or effective-address computation. Update pc/npc.
  - LOAD_WAIT: same fill procedure as FETCH_WAIT, capturing the beat at index addr[4:2] into rt. Returns to FETCH.
  - STORE: `Addr`=addr, drive `Bus`=rt, `Write`=1 for exactly one cycle. Returns to FETCH.

## Timing
- Reset while `MRST`=0: `Read`=0, `Write`=0, `Addr`=0, `Bus` high-Z, pc=`RESET_PC`, npc=`RESET_PC`+4, FSM=FETCH. Register contents are undefined except r0.
- Reset asserted mid-fill or mid-store aborts immediately. `Read` and `Write` drop asynchronously.
- Fill latency is set by memory (≥200 time units before the first `Valid`). The CPU waits indefinitely. `Addr` and `Read` stay stable from request until the edge that samples beat 7.
- `Read` is low for at least one full cycle between consecutive fills; FSM ordering guarantees this.
- `Read` and `Write` are never high together.
- `Valid` is sampled on the rising edge. Beats need not be contiguous; only edges with `Valid`=1 advance the beat counter.
- Cycle counts per instruction: ALU/branch/jump = fill + 1; LW = 2 fills + 1; SW = fill + 2.

## Structure
- Package `mips_pkg`: opcode/funct constants, FSM state enum, `RESET_PC`, `LINE_WORDS`.
- Sub-module `cpu_regfile`: 2 async read ports, 1 sync write port, r0 hardwired to 0.
- ALU and decode stay inline in `cpu`.

## Test plan
- Reset: `MRST` low → `Read`=0, `Write`=0, `Bus`=Z. After release → `Read`=1 with `Addr`=0 on the first edge.
- Fill capture: memory returns words 0x100+i on beats i=0..7, pc=0x8 → IR=0x102. `Read` low after beat 7.
- ALU: ADDIU r1,r0,5; ADDU r2,r1,r1; SW r2,0x40(r0) → `Write` pulse, `Addr`=0x40, `Bus`=10.
- Load: LW r3,0x24(r0) with the line at 0x20 holding 0xDEAD_BEEF at beat 1 → later SW r3 writes 0xDEAD_BEEF.
- Delay slot: BEQ r0,r0,+4 then ADDIU r4,r0,7 → the slot executes (r4=7) and fetch jumps to the target.
- Reset mid-fill after beat 3 → `Read` drops at once. After release, the next fill restarts at `Addr`=0.
